// File: rtl/key_word_buff_pkg.sv
// key_exp_pkg: key-size encodings, schedule defaults and Nk/TOTAL lookup for the key word buffer
package key_exp_pkg;

    localparam logic [1:0] CONF_128 = 2'b00;
    localparam logic [1:0] CONF_192 = 2'b01;
    localparam logic [1:0] CONF_256 = 2'b10;

    localparam int DEF_DEPTH0 = 4;
    localparam int DEF_DEPTH1 = 6;
    localparam int DEF_DEPTH2 = 8;
    localparam int DEF_TOTAL0 = 44;
    localparam int DEF_TOTAL1 = 52;
    localparam int DEF_TOTAL2 = 60;

    typedef struct packed {
        logic [3:0]  nk;
        logic [15:0] total;
    } sched_t;

    // conf 2'b11 falls through to the AES-256 entry
    function automatic sched_t key_sched(input logic [1:0] conf,
                                         input int d0, input int d1, input int d2,
                                         input int t0, input int t1, input int t2);
        sched_t s;
        s.nk    = conf == CONF_128 ? 4'(d0)  : conf == CONF_192 ? 4'(d1)  : 4'(d2);
        s.total = conf == CONF_128 ? 16'(t0) : conf == CONF_192 ? 16'(t1) : 16'(t2);
        return s;
    endfunction

endpackage

// File: rtl/key_word_buff_if.sv
// key_word_buff_if: push/config inputs and buffer status outputs of the key word buffer
interface key_word_buff_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
);
    logic              clear_in;
    logic              enable_in;
    logic [1:0]        conf_in;
    logic [DATA_W-1:0] buff_in;
    logic [DATA_W-1:0] buff_out;
    logic              valid_out;
    logic [3:0]        mod_idx_out;
    logic [CNT_W-1:0]  word_cnt_out;
    logic              done_out;

    modport master (
        output clear_in, enable_in, conf_in, buff_in,
        input  buff_out, valid_out, mod_idx_out, word_cnt_out, done_out
    );

    modport slave (
        input  clear_in, enable_in, conf_in, buff_in,
        output buff_out, valid_out, mod_idx_out, word_cnt_out, done_out
    );
endinterface

// File: rtl/key_word_buff_ctrl.sv
// key_buff_ctrl: conf tracking, flush/push arbitration and fill/word/index counters
import key_exp_pkg::*;

module key_buff_ctrl #(
    parameter int DEPTH0 = DEF_DEPTH0,
    parameter int DEPTH1 = DEF_DEPTH1,
    parameter int DEPTH2 = DEF_DEPTH2,
    parameter int TOTAL0 = DEF_TOTAL0,
    parameter int TOTAL1 = DEF_TOTAL1,
    parameter int TOTAL2 = DEF_TOTAL2,
    parameter int CNT_W  = 6
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             clear_in,
    input  logic             enable_in,
    input  logic [1:0]       conf_in,
    output logic             flush,
    output logic             push,
    output logic [3:0]       nk,
    output logic             valid,
    output logic             done,
    output logic [3:0]       mod_idx,
    output logic [CNT_W-1:0] word_cnt
);
    logic [1:0] conf_q;
    logic [3:0] fill_cnt;
    sched_t     sched;

    assign sched = key_sched(conf_q, DEPTH0, DEPTH1, DEPTH2, TOTAL0, TOTAL1, TOTAL2);
    assign nk    = sched.nk;
    assign flush = clear_in || conf_in != conf_q;
    assign push  = !flush && enable_in && !done;
    assign valid = fill_cnt == nk;
    assign done  = 16'(word_cnt) == sched.total;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            conf_q   <= CONF_128;
            fill_cnt <= '0;
            word_cnt <= '0;
            mod_idx  <= '0;
        end else if (flush) begin
            conf_q   <= conf_in;
            fill_cnt <= '0;
            word_cnt <= '0;
            mod_idx  <= '0;
        end else if (push) begin
            fill_cnt <= valid ? fill_cnt : fill_cnt + 4'd1;
            word_cnt <= word_cnt + 1'b1;
            mod_idx  <= mod_idx == nk - 4'd1 ? 4'd0 : mod_idx + 4'd1;
        end
    end
endmodule

// File: rtl/key_word_buff.sv
// key_word_buff: sliding w[i-Nk] buffer for AES key expansion.
// Define KEY_BUFF_TAPS_EN to expose every stage on taps_out.
import key_exp_pkg::*;

module key_word_buff #(
    parameter int DATA_W = 32,
    parameter int DEPTH0 = DEF_DEPTH0,
    parameter int DEPTH1 = DEF_DEPTH1,
    parameter int DEPTH2 = DEF_DEPTH2,
    parameter int TOTAL0 = DEF_TOTAL0,
    parameter int TOTAL1 = DEF_TOTAL1,
    parameter int TOTAL2 = DEF_TOTAL2,
    parameter int CNT_W  = 6,
    localparam int MAX01 = DEPTH0 > DEPTH1 ? DEPTH0 : DEPTH1,
    localparam int MAX_D = MAX01 > DEPTH2 ? MAX01 : DEPTH2
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
`ifdef KEY_BUFF_TAPS_EN
    output logic [MAX_D*DATA_W-1:0] taps_out,
`endif
    key_word_buff_if.slave          bus
);
    localparam int SEL_W = MAX_D > 1 ? $clog2(MAX_D) : 1;

    logic              flush;
    logic              push;
    logic [3:0]        nk;
    logic [DATA_W-1:0] stage [MAX_D];
    logic [SEL_W-1:0]  sel;

    key_buff_ctrl #(
        .DEPTH0(DEPTH0), .DEPTH1(DEPTH1), .DEPTH2(DEPTH2),
        .TOTAL0(TOTAL0), .TOTAL1(TOTAL1), .TOTAL2(TOTAL2),
        .CNT_W(CNT_W)
    ) u_ctrl (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clear_in (bus.clear_in),
        .enable_in(bus.enable_in),
        .conf_in  (bus.conf_in),
        .flush    (flush),
        .push     (push),
        .nk       (nk),
        .valid    (bus.valid_out),
        .done     (bus.done_out),
        .mod_idx  (bus.mod_idx_out),
        .word_cnt (bus.word_cnt_out)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in || flush) begin
            for (int k = 0; k < MAX_D; k++) stage[k] <= '0;
        end else if (push) begin
            stage[0] <= bus.buff_in;
            for (int k = 1; k < MAX_D; k++) stage[k] <= stage[k-1];
        end
    end

    assign sel          = SEL_W'(nk - 4'd1);
    assign bus.buff_out = stage[sel];

`ifdef KEY_BUFF_TAPS_EN
    for (genvar g = 0; g < MAX_D; g++) begin : g_taps
        assign taps_out[g*DATA_W +: DATA_W] = stage[g];
    end
`endif
endmodule
